// File: rtl/nq_apb_pkg.sv
// Shared definitions for the nanoQuarter APB data-memory path (master, slave, bench).
package nq_apb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_WAIT,
    ST_RESP
  } apb_state_e;

  localparam logic [31:0] ERR_DATA      = 32'hFFFF_FFFF;
  localparam int          MEM_DEPTH_DEF = 256;
  localparam int          TIMEOUT_DEF   = 4;

  // Width of the WAIT counter; never zero so TIMEOUT = 0 still elaborates.
  function automatic int cnt_w(input int t);
    return (t < 1) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/apb_master_if.sv
// CPU request/response handshake plus the APB bus wires of the data-memory path.
interface apb_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pvalid;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, prdata, pvalid,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, prdata, pvalid,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_master.sv
// APB requester: one CPU request at a time turned into SETUP/ACCESS, with range check
// and a bounded wait for read data.
module apb_master
  import nq_apb_pkg::*;
#(
  parameter int MEM_DEPTH = MEM_DEPTH_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic         clk,
  input  logic         rst,
  apb_master_if.master bus
);

  localparam int CW = cnt_w(TIMEOUT);

  apb_state_e  r_state, w_next;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic        r_req_ready, r_rsp_valid, r_rsp_err;
  logic        r_psel, r_penable, r_pwrite;
  logic [31:0] r_rsp_rdata, r_paddr, r_pwdata;
  logic        w_err_nxt, w_bus_ld, w_timeout;
  logic [31:0] w_rdata_nxt;

  // This WAIT cycle is the TIMEOUT-th one without pvalid.
  assign w_timeout = (32'(r_cnt) + 32'd1) >= 32'(TIMEOUT);

  always_comb begin
    w_next      = r_state;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = 1'b0;
    w_bus_ld    = 1'b0;
    w_rdata_nxt = r_rsp_rdata;
    case (r_state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (bus.req_addr >= 32'(MEM_DEPTH)) begin
            w_next      = ST_RESP;
            w_err_nxt   = 1'b1;
            w_rdata_nxt = ERR_DATA;
          end else begin
            w_next   = ST_SETUP;
            w_bus_ld = 1'b1;
          end
        end
      end
      ST_SETUP:  w_next = ST_ACCESS;
      ST_ACCESS: begin
        if (r_pwrite) begin
          w_next = ST_RESP;
        end else begin
          w_next    = ST_WAIT;
          w_cnt_nxt = '0;
        end
      end
      ST_WAIT: begin
        if (bus.pvalid) begin
          w_next      = ST_RESP;
          w_rdata_nxt = bus.prdata;
        end else if (w_timeout) begin
          w_next      = ST_RESP;
          w_err_nxt   = 1'b1;
          w_rdata_nxt = ERR_DATA;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
    end else begin
      r_state     <= w_next;
      r_cnt       <= w_cnt_nxt;
      r_req_ready <= (w_next == ST_IDLE);
      r_rsp_valid <= (w_next == ST_RESP);
      r_rsp_err   <= w_err_nxt;
      r_rsp_rdata <= w_rdata_nxt;
      r_psel      <= (w_next == ST_SETUP) || (w_next == ST_ACCESS);
      r_penable   <= (w_next == ST_ACCESS);
      if (w_bus_ld) begin
        r_pwrite <= bus.req_write;
        r_paddr  <= bus.req_addr;
        r_pwdata <= bus.req_wdata;
      end
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.psel      = r_psel;
  assign bus.penable   = r_penable;
  assign bus.pwrite    = r_pwrite;
  assign bus.paddr     = r_paddr;
  assign bus.pwdata    = r_pwdata;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: behavioural data-memory slave, vector table, corner sequences.
module tb_apb_master;
  import nq_apb_pkg::*;

  logic clk, rst;
  apb_master_if bus();

  apb_master #(.MEM_DEPTH(MEM_DEPTH_DEF), .TIMEOUT(TIMEOUT_DEF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave model: writes on ACCESS, read data + pvalid on the first WAIT cycle.
  logic [31:0] mem [256];
  logic        s_pvalid, stub_mode, spur_pv;
  logic [31:0] s_prdata, spur_data;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_pvalid <= 1'b0;
      s_prdata <= '0;
    end else begin
      s_pvalid <= 1'b0;
      if (bus.psel && bus.penable && !bus.pwrite && !stub_mode) begin
        s_pvalid <= 1'b1;
        s_prdata <= mem[bus.paddr[7:0]];
      end
    end
  end

  always @(posedge clk)
    if (!rst && bus.psel && bus.penable && bus.pwrite) mem[bus.paddr[7:0]] <= bus.pwdata;

  assign bus.pvalid = s_pvalid | spur_pv;
  assign bus.prdata = spur_pv ? spur_data : s_prdata;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stub;
    int          lat;
    logic        err;
    logic [31:0] rdata;
    int          nbus;
  } vec_t;

  // Entered at a negedge in IDLE; returns cycles from accept edge to rsp_valid (-1 on budget expiry).
  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic err, output logic [31:0] rd,
                        output int n_setup, output int n_access, output logic [31:0] acc_addr);
    lat = -1; err = 1'bx; rd = 'x; n_setup = 0; n_access = 0; acc_addr = '0;
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_addr = a; bus.req_wdata = d;
    @(posedge clk);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      if (bus.psel && !bus.penable) n_setup++;
      if (bus.psel && bus.penable) begin n_access++; acc_addr = bus.paddr; end
      if (bus.rsp_valid) begin lat = c; err = bus.rsp_err; rd = bus.rsp_rdata; break; end
    end
  endtask

  vec_t        vt [11];
  int          lat, ns, na, cnt;
  logic        err;
  logic [31:0] rd, aa;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{1'b1, 32'd8,          32'hDEAD_BEEF, 1'b0, 3, 1'b0, 32'h0,         1};
    vt[1]  = '{1'b0, 32'd8,          32'h0,         1'b0, 4, 1'b0, 32'hDEAD_BEEF, 1};
    vt[2]  = '{1'b0, 32'd256,        32'h0,         1'b0, 1, 1'b1, 32'hFFFF_FFFF, 0};
    vt[3]  = '{1'b0, 32'hFFFF_FFFF,  32'h0,         1'b0, 1, 1'b1, 32'hFFFF_FFFF, 0};
    vt[4]  = '{1'b1, 32'd5,          32'h5555_AAAA, 1'b0, 3, 1'b0, 32'hFFFF_FFFF, 1};
    vt[5]  = '{1'b1, 32'd255,        32'h0BAD_F00D, 1'b0, 3, 1'b0, 32'hFFFF_FFFF, 1};
    vt[6]  = '{1'b0, 32'd255,        32'h0,         1'b0, 4, 1'b0, 32'h0BAD_F00D, 1};
    vt[7]  = '{1'b0, 32'd5,          32'h0,         1'b0, 4, 1'b0, 32'h5555_AAAA, 1};
    vt[8]  = '{1'b1, 32'd256,        32'h1,         1'b0, 1, 1'b1, 32'hFFFF_FFFF, 0};
    vt[9]  = '{1'b0, 32'd3,          32'h0,         1'b1, 7, 1'b1, 32'hFFFF_FFFF, 1};
    vt[10] = '{1'b0, 32'd8,          32'h0,         1'b0, 4, 1'b0, 32'hDEAD_BEEF, 1};

    rst = 1'b1; stub_mode = 1'b0; spur_pv = 1'b0; spur_data = '0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {28'd0, bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.pwrite}, 32'h8);
    chk("reset_psel", {30'd0, bus.psel, bus.penable}, 32'h0);
    chk("reset_rdata", bus.rsp_rdata, 32'h0);
    chk("reset_paddr", bus.paddr, 32'h0);
    chk("reset_pwdata", bus.pwdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      stub_mode = vt[i].stub;
      do_req(vt[i].wr, vt[i].addr, vt[i].wdata, lat, err, rd, ns, na, aa);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vt[i].lat));
      chk($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, vt[i].err});
      chk($sformatf("v%0d_rdata", i), rd, vt[i].rdata);
      chk($sformatf("v%0d_setup_access", i), {16'(ns), 16'(na)},
          {16'(vt[i].nbus), 16'(vt[i].nbus)});
      chk($sformatf("v%0d_paddr", i), aa, vt[i].nbus != 0 ? vt[i].addr : 32'h0);
      @(negedge clk);
      chk($sformatf("v%0d_idle_after", i), {30'd0, bus.req_ready, bus.rsp_valid}, 32'h2);
    end
    stub_mode = 1'b0;

    // Back-to-back writes with req_valid held: expect SETUP, ACCESS, RESP, then an IDLE gap.
    bus.req_valid = 1'b1; bus.req_write = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.req_addr = 32'(k); bus.req_wdata = 32'hB0B0_0000 + 32'(k);
      chk($sformatf("b2b%0d_idle", k), {28'd0, bus.psel, bus.penable, bus.req_ready, bus.rsp_valid}, 32'h2);
      @(posedge clk); @(negedge clk);
      chk($sformatf("b2b%0d_setup", k), {28'd0, bus.psel, bus.penable, bus.req_ready, bus.rsp_valid}, 32'h8);
      @(negedge clk);
      chk($sformatf("b2b%0d_access", k), {28'd0, bus.psel, bus.penable, bus.req_ready, bus.rsp_valid}, 32'hC);
      @(negedge clk);
      chk($sformatf("b2b%0d_resp", k), {28'd0, bus.psel, bus.penable, bus.req_ready, bus.rsp_valid}, 32'h1);
      if (k == 2) bus.req_valid = 1'b0;
      @(negedge clk);
    end
    for (int k = 0; k < 3; k++) chk($sformatf("b2b_mem%0d", k), mem[k], 32'hB0B0_0000 + 32'(k));

    // Spurious pvalid while idle, then during a write's ACCESS.
    spur_data = 32'h1234; spur_pv = 1'b1;
    @(negedge clk);
    spur_pv = 1'b0;
    chk("spur_idle_valid", {31'd0, bus.rsp_valid}, 32'h0);
    chk("spur_idle_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 32'd9; bus.req_wdata = 32'h99;
    @(posedge clk); @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    spur_pv = 1'b1;
    @(negedge clk);
    spur_pv = 1'b0;
    chk("spur_wr_resp", {30'd0, bus.rsp_valid, bus.rsp_err}, 32'h2);
    chk("spur_wr_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
    cnt = 0;
    repeat (4) begin @(negedge clk); if (bus.rsp_valid) cnt++; end
    chk("spur_extra_rsp", 32'(cnt), 32'h0);

    // Reset asserted mid-ACCESS of a read must clear outputs before the next edge.
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'd5;
    @(posedge clk); @(negedge clk);
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("pre_reset_access", {30'd0, bus.psel, bus.penable}, 32'h3);
    #1 rst = 1'b1;
    #1;
    chk("async_reset_outs", {28'd0, bus.psel, bus.penable, bus.rsp_valid, bus.req_ready}, 32'h1);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    repeat (6) begin @(negedge clk); if (bus.rsp_valid) cnt++; end
    chk("post_reset_no_rsp", 32'(cnt), 32'h0);
    chk("post_reset_ready", {31'd0, bus.req_ready}, 32'h1);
    do_req(1'b0, 32'd5, 32'h0, lat, err, rd, ns, na, aa);
    chk("post_reset_rd_lat", 32'(lat), 32'd4);
    chk("post_reset_rd_data", rd, 32'h5555_AAAA);
    chk("post_reset_rd_err", {31'd0, err}, 32'h0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
